round_scheduler: RTL and testbench
==================================

# round_scheduler

Game-round sequencer that drives every game-state input of `display_controller`: `game_state`, `fire_state`, `gold_state`, `next_fire_pattern`, `life`, `score` and `win`. It runs the INIT → PLAY → FINISH flow and a timed WARN/FIRE round loop. It generates pseudo-random fire patterns and a gold cell each round. It scores the player's grid position (`box`) against them at the end of each FIRE phase.

## Interface
Parameters:
- `TICK_DIV`, 25_000_000: clk cycles per game tick.
- `WARN_TICKS`, 2: ticks per WARN phase (≥1).
- `FIRE_TICKS`, 1: ticks per FIRE phase (≥1).
- `LIFE_MAX`, 3: starting lives (≤3).
- `SCORE_MAX`, 5: score that wins (≤15).
- `LFSR_SEED`, 9'h1A5: LFSR reset value (nonzero).

Ports:
- `clk`  in  1: system clock. One clock only.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: single-cycle pulse from the debounced button.
- `box`  in  9: player position, one-hot over the 3×3 grid (bit = row*3+col). Non-one-hot values are legal.
- `game_state`  out  2: INIT=00, PLAY=01, FINISH=10.
- `fire_state`  out  9: cells burning now.
- `gold_state`  out  9: one-hot gold cell, or 0.
- `next_fire_pattern`  out  9: preview pattern for the mini grid.
- `life`  out  2: remaining lives.
- `score`  out  4: gold collected.
- `win`  out  1: 1 = won, valid in FINISH.

## Operation
- All outputs are registered.
- Reset values: `game_state`=INIT, `fire_state`=0, `gold_state`=0, `next_fire_pattern`=0, `life`=LIFE_MAX, `score`=0, `win`=0, LFSR=LFSR_SEED. Internal counters reset to 0.
- LFSR: 9-bit Fibonacci LFSR, polynomial x^9+x^5+1. Free-running every cycle in all states, so start timing seeds the randomness. It never reaches 0.
- Pattern draw: pattern = LFSR value; if it equals 9'h1FF, clear bit 4. Gold = one-hot of the lowest-index 0 bit of the pattern. Fire and gold are therefore always disjoint, and gold always exists.
- Top FSM:
  - INIT + `start` → PLAY. On entry: life=LIFE_MAX, score=0, win=0, enter WARN with `cur` drawn.
  - PLAY ignores `start`.
  - FINISH + `start` → INIT. On entry to INIT, fire, gold and next are cleared; life and score stay held.
- Tick counter: counts 0..TICK_DIV-1 only in PLAY, emitting a 1-cycle tick at TICK_DIV-1. It is cleared on PLAY entry and on every phase change.
- Phase counter counts ticks within the current phase.
- WARN phase:
  - `next_fire_pattern`=cur, `fire_state`=0, `gold_state`=gold(cur).
  - After WARN_TICKS ticks → FIRE.
- FIRE phase:
  - On entry: `fire_state`=cur, `nxt` drawn, `next_fire_pattern`=nxt, gold held.
  - On the final FIRE tick, sample `box`:
    - (box & fire_state)≠0 → life−1.
    - Else (box & gold_state)≠0 → score+1.
    - Else no change.
  - Then, on the same edge:
    - life==0 → FINISH, win=0.
    - Else score==SCORE_MAX → FINISH, win=1.
    - Else → WARN with cur=nxt and gold recomputed.
- FINISH: fire, gold and next are all 0; life, score and win are held.
- Saturation: life never wraps below 0, and score never exceeds SCORE_MAX.

## Timing
- `start` is sampled at a rising edge; `game_state` changes on that edge, visible the next cycle.
- WARN lasts exactly WARN_TICKS*TICK_DIV cycles. FIRE lasts exactly FIRE_TICKS*TICK_DIV cycles.
- Evaluation, the life/score update and the state change all occur on the same edge. FINISH and the final life/score/win values appear together.
- `start` coinciding with a tick in PLAY is ignored.
- `rst` asserted mid-round has priority over everything: the next cycle shows the reset values.

## Structure
- Shared package `game_pkg`:
  - Game state encodings INIT, PLAY and FINISH, also used by `display_controller`.
  - LIFE_MAX and SCORE_MAX defaults.
  - Grid cell count (9).
- Sub-module `lfsr9`: parameterised seed, with ports `clk`, `rst` and output `q[8:0]`.
- The pattern sanitiser and gold priority encoder are combinational functions inside `round_scheduler`.

## Test plan
All scenarios use TICK_DIV=4, WARN_TICKS=2, FIRE_TICKS=1.
- Reset: hold `rst` 2 cycles → game_state=00, life=3, score=0, win=0, fire, gold and next all 0.
- Start: pulse `start` in INIT → next cycle game_state=01, life=3, next_fire_pattern≠0, fire_state=0, exactly one gold bit and gold&next=0. 8 cycles later fire_state equals the previous preview, and next_fire_pattern shows a new draw.
- Hit: drive box onto a fire_state bit through the FIRE end → life 3→2 on the end edge, phase returns to WARN. Repeat twice more → life=0, game_state=10, win=0, all grids 0.
- Gold: drive box onto the gold cell each round, 5 rounds → score increments 1..5. After the 5th: game_state=10, win=1.
- Idle: box=9'h000, or box on a neutral cell → life and score unchanged across 3 rounds. A `start` pulse mid-PLAY has no effect.
- Restart and reset: in FINISH, `start` → INIT with grids 0; a second `start` → PLAY with life=3, score=0. Asserting `rst` mid-FIRE → reset values next cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions for the round scheduler and the display controller.
package game_pkg;

  localparam int unsigned GRID_CELLS = 9;
  localparam int unsigned LIFE_MAX_DEFAULT = 3;
  localparam int unsigned SCORE_MAX_DEFAULT = 5;

  typedef logic [GRID_CELLS-1:0] grid_t;

  typedef enum logic [1:0] {
    GsInit   = 2'b00,
    GsPlay   = 2'b01,
    GsFinish = 2'b10
  } game_state_e;

endpackage

// File: rtl/round_scheduler_if.sv
// Game-state bundle between the button/position logic, the scheduler and the display.
interface round_scheduler_if;
  import game_pkg::*;

  logic        start;
  grid_t       box;
  logic [1:0]  game_state;
  grid_t       fire_state;
  grid_t       gold_state;
  grid_t       next_fire_pattern;
  logic [1:0]  life;
  logic [3:0]  score;
  logic        win;

  // Scheduler side: consumes start/box, produces all game-state outputs.
  modport master (
    input  start, box,
    output game_state, fire_state, gold_state, next_fire_pattern, life, score, win
  );

  // Environment side: drives start/box, observes the game state.
  modport slave (
    output start, box,
    input  game_state, fire_state, gold_state, next_fire_pattern, life, score, win
  );
endinterface

// File: rtl/lfsr9.sv
// Free-running 9-bit Fibonacci LFSR, polynomial x^9 + x^5 + 1.
module lfsr9 #(
  parameter logic [8:0] SEED = 9'h1A5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [8:0] q
);

  // Shift every cycle; a nonzero seed never reaches the all-zero lock-up state.
  always_ff @(posedge clk) begin
    if (rst) q <= SEED;
    else     q <= {q[7:0], q[8] ^ q[4]};
  end

endmodule

// File: rtl/round_scheduler.sv
// Game-round sequencer: INIT -> PLAY -> FINISH flow with timed WARN/FIRE rounds,
// random fire/gold generation and per-round scoring of the player position.
module round_scheduler
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 25_000_000,
  parameter int unsigned WARN_TICKS = 2,
  parameter int unsigned FIRE_TICKS = 1,
  parameter int unsigned LIFE_MAX   = LIFE_MAX_DEFAULT,
  parameter int unsigned SCORE_MAX  = SCORE_MAX_DEFAULT,
  parameter logic [8:0]  LFSR_SEED  = 9'h1A5
) (
  input logic               clk,
  input logic               rst,
  round_scheduler_if.master bus
);

  localparam int unsigned TW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PH_MAX = (WARN_TICKS > FIRE_TICKS) ? WARN_TICKS : FIRE_TICKS;
  localparam int unsigned PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  typedef enum logic {PhWarn, PhFire} phase_e;

  // An all-ones draw would leave no free cell for gold, so knock out the centre.
  function automatic grid_t sanitise(input grid_t v);
    return (v == 9'h1FF) ? (v & 9'h1EF) : v;
  endfunction

  // One-hot of the lowest-index cell not on fire.
  function automatic grid_t gold_of(input grid_t p);
    grid_t g;
    g = '0;
    for (int i = GRID_CELLS - 1; i >= 0; i--) begin
      if (!p[i]) begin
        g    = '0;
        g[i] = 1'b1;
      end
    end
    return g;
  endfunction

  logic [8:0]  lfsr_val;
  game_state_e state_q;
  phase_e      phase_q;
  logic [TW-1:0] tick_cnt_q;
  logic [PW-1:0] phase_cnt_q;
  grid_t       cur_q, nxt_q, fire_q, gold_q, next_q;
  logic [1:0]  life_q;
  logic [3:0]  score_q;
  logic        win_q;

  grid_t       draw;
  logic        tick;
  logic        hit, got;
  logic [1:0]  life_eval;
  logic [3:0]  score_eval;

  lfsr9 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_val)
  );

  // Round draw, tick strobe and end-of-FIRE evaluation of the player position.
  always_comb begin
    draw       = sanitise(lfsr_val);
    tick       = (state_q == GsPlay) && (tick_cnt_q == TW'(TICK_DIV - 1));
    hit        = |(bus.box & fire_q);
    got        = |(bus.box & gold_q);
    life_eval  = life_q;
    score_eval = score_q;
    if (hit) begin
      if (life_q != 2'd0) life_eval = life_q - 2'd1;
    end else if (got && (score_q < 4'(SCORE_MAX))) begin
      score_eval = score_q + 4'd1;
    end
  end

  // Game FSM with registered outputs; reset has priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= GsInit;
      phase_q     <= PhWarn;
      tick_cnt_q  <= '0;
      phase_cnt_q <= '0;
      cur_q       <= '0;
      nxt_q       <= '0;
      fire_q      <= '0;
      gold_q      <= '0;
      next_q      <= '0;
      life_q      <= 2'(LIFE_MAX);
      score_q     <= '0;
      win_q       <= 1'b0;
    end else begin
      unique case (state_q)
        GsInit: begin
          if (bus.start) begin
            state_q     <= GsPlay;
            phase_q     <= PhWarn;
            tick_cnt_q  <= '0;
            phase_cnt_q <= '0;
            life_q      <= 2'(LIFE_MAX);
            score_q     <= '0;
            win_q       <= 1'b0;
            cur_q       <= draw;
            next_q      <= draw;
            fire_q      <= '0;
            gold_q      <= gold_of(draw);
          end
        end
        GsPlay: begin
          if (!tick) begin
            tick_cnt_q <= tick_cnt_q + TW'(1);
          end else begin
            tick_cnt_q <= '0;
            if (phase_q == PhWarn) begin
              if (phase_cnt_q == PW'(WARN_TICKS - 1)) begin
                phase_q     <= PhFire;
                phase_cnt_q <= '0;
                fire_q      <= cur_q;
                nxt_q       <= draw;
                next_q      <= draw;
              end else begin
                phase_cnt_q <= phase_cnt_q + PW'(1);
              end
            end else if (phase_cnt_q == PW'(FIRE_TICKS - 1)) begin
              // Scoring and the round outcome commit on the same edge.
              phase_cnt_q <= '0;
              life_q      <= life_eval;
              score_q     <= score_eval;
              if ((life_eval == 2'd0) || (score_eval == 4'(SCORE_MAX))) begin
                state_q <= GsFinish;
                win_q   <= (life_eval != 2'd0);
                fire_q  <= '0;
                gold_q  <= '0;
                next_q  <= '0;
              end else begin
                phase_q <= PhWarn;
                cur_q   <= nxt_q;
                fire_q  <= '0;
                next_q  <= nxt_q;
                gold_q  <= gold_of(nxt_q);
              end
            end else begin
              phase_cnt_q <= phase_cnt_q + PW'(1);
            end
          end
        end
        GsFinish: begin
          if (bus.start) begin
            state_q <= GsInit;
            fire_q  <= '0;
            gold_q  <= '0;
            next_q  <= '0;
          end
        end
        default: state_q <= GsInit;
      endcase
    end
  end

  assign bus.game_state        = state_q;
  assign bus.fire_state        = fire_q;
  assign bus.gold_state        = gold_q;
  assign bus.next_fire_pattern = next_q;
  assign bus.life              = life_q;
  assign bus.score             = score_q;
  assign bus.win               = win_q;

endmodule

// File: tb/tb_round_scheduler.sv
// Self-checking bench for round_scheduler against a cycle-budget reference model.
module tb_round_scheduler;

  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned WARN_TICKS = 2;
  localparam int unsigned FIRE_TICKS = 1;
  localparam int unsigned LIFE       = 3;
  localparam int unsigned SCORE      = 5;
  localparam logic [8:0]  SEED       = 9'h1A5;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic [8:0] box   = 9'h000;

  int tests = 0;
  int fails = 0;

  round_scheduler_if bus ();
  assign bus.start = start;
  assign bus.box   = box;

  round_scheduler #(
    .TICK_DIV   (TICK_DIV),
    .WARN_TICKS (WARN_TICKS),
    .FIRE_TICKS (FIRE_TICKS),
    .LIFE_MAX   (LIFE),
    .SCORE_MAX  (SCORE),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: game state plus a cycle budget remaining in the current phase.
  logic [8:0] m_lfsr = SEED;
  logic [8:0] m_cur = '0, m_nxt = '0, m_fire = '0, m_gold = '0, m_next = '0;
  int         m_state = 0;  // 0 init, 1 play, 2 finish
  int         m_life = LIFE, m_score = 0, m_left = 0;
  bit         m_warn = 1'b1;
  logic       m_win = 1'b0;

  function automatic logic [8:0] m_san(input logic [8:0] v);
    return (v == 9'h1FF) ? 9'h1EF : v;
  endfunction

  // Lowest zero bit of p, isolated arithmetically.
  function automatic logic [8:0] m_goldf(input logic [8:0] p);
    logic [8:0] inc;
    inc = p + 9'd1;
    return ~p & inc;
  endfunction

  task automatic model_step();
    logic [8:0] d;
    if (rst) begin
      m_state = 0; m_warn = 1'b1; m_left = 0;
      m_cur = '0; m_nxt = '0; m_fire = '0; m_gold = '0; m_next = '0;
      m_life = LIFE; m_score = 0; m_win = 1'b0; m_lfsr = SEED;
      return;
    end
    d = m_san(m_lfsr);
    if (m_state == 0) begin
      if (start) begin
        m_state = 1; m_life = LIFE; m_score = 0; m_win = 1'b0;
        m_warn = 1'b1; m_left = WARN_TICKS * TICK_DIV;
        m_cur = d; m_next = d; m_fire = '0; m_gold = m_goldf(d);
      end
    end else if (m_state == 1) begin
      m_left--;
      if (m_left == 0) begin
        if (m_warn) begin
          m_warn = 1'b0; m_left = FIRE_TICKS * TICK_DIV;
          m_fire = m_cur; m_nxt = d; m_next = d;
        end else begin
          if ((box & m_fire) != 0) begin
            if (m_life > 0) m_life--;
          end else if ((box & m_gold) != 0) begin
            if (m_score < SCORE) m_score++;
          end
          if (m_life == 0 || m_score == SCORE) begin
            m_state = 2; m_win = (m_life != 0);
            m_fire = '0; m_gold = '0; m_next = '0;
          end else begin
            m_warn = 1'b1; m_left = WARN_TICKS * TICK_DIV;
            m_cur = m_nxt; m_fire = '0; m_next = m_nxt; m_gold = m_goldf(m_nxt);
          end
        end
      end
    end else if (start) begin
      m_state = 0; m_fire = '0; m_gold = '0; m_next = '0;
    end
    m_lfsr = {m_lfsr[7:0], m_lfsr[8] ^ m_lfsr[4]};
  endtask

  // One clock: DUT and model advance on the edge, sampling happens on the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  function automatic logic [35:0] dut_vec();
    return {bus.game_state, bus.fire_state, bus.gold_state, bus.next_fire_pattern,
            bus.life, bus.score, bus.win};
  endfunction

  function automatic logic [35:0] mod_vec();
    return {2'(m_state), m_fire, m_gold, m_next, 2'(m_life), 4'(m_score), m_win};
  endfunction

  function automatic logic [8:0] pick_neutral();
    logic [8:0] free;
    int n, k;
    free = ~(m_fire | m_gold);
    if (free == 9'h000 || $urandom_range(0, 1) == 0) return 9'h000;
    n = $countones(free);
    k = $urandom_range(0, n - 1);
    for (int i = 0; i < 9; i++) begin
      if (free[i]) begin
        if (k == 0) return 9'(1) << i;
        k--;
      end
    end
    return 9'h000;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    tests++;
    if ({bus.game_state, bus.life, bus.score, bus.win} !== {2'b00, 2'd3, 4'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_regs: got %h want %h",
               {bus.game_state, bus.life, bus.score, bus.win}, {2'b00, 2'd3, 4'd0, 1'b0});
    end
    tests++;
    if ({bus.fire_state, bus.gold_state, bus.next_fire_pattern} !== 27'd0) begin
      fails++;
      $display("FAIL reset_grids: got %h want 0",
               {bus.fire_state, bus.gold_state, bus.next_fire_pattern});
    end
    rst = 1'b0;
  endtask

  task automatic test_start();
    logic [8:0] preview;
    int w;
    w = $urandom_range(0, 15);
    for (int i = 0; i < w; i++) cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    tests++;
    if (bus.game_state !== 2'b01 || bus.life !== 2'd3 || bus.fire_state !== 9'h000) begin
      fails++;
      $display("FAIL start_state: got gs=%b life=%0d fire=%h want gs=01 life=3 fire=0",
               bus.game_state, bus.life, bus.fire_state);
    end
    tests++;
    if (bus.next_fire_pattern === 9'h000 || $countones(bus.gold_state) != 1 ||
        (bus.gold_state & bus.next_fire_pattern) !== 9'h000) begin
      fails++;
      $display("FAIL start_draw: got next=%h gold=%h want next!=0, one-hot gold disjoint",
               bus.next_fire_pattern, bus.gold_state);
    end
    tests++;
    if (dut_vec() !== mod_vec()) begin
      fails++;
      $display("FAIL start_model: got %h want %h", dut_vec(), mod_vec());
    end
    preview = m_next;
    for (int i = 0; i < 7; i++) cyc();
    tests++;
    if (bus.fire_state !== 9'h000) begin
      fails++;
      $display("FAIL warn_len: got fire=%h want 0 after 7 cycles", bus.fire_state);
    end
    cyc();
    tests++;
    if (bus.fire_state !== preview || bus.next_fire_pattern !== m_next) begin
      fails++;
      $display("FAIL fire_entry: got fire=%h next=%h want fire=%h next=%h",
               bus.fire_state, bus.next_fire_pattern, preview, m_next);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 36; i++) begin
      box   = pick_neutral();
      start = (i == 17);
      cyc();
      tests++;
      if (dut_vec() !== mod_vec()) begin
        fails++;
        $display("FAIL idle_c%0d: got %h want %h", i, dut_vec(), mod_vec());
      end
    end
    start = 1'b0;
    box   = 9'h000;
    tests++;
    if (bus.game_state !== 2'b01 || bus.life !== 2'd3 || bus.score !== 4'd0) begin
      fails++;
      $display("FAIL idle_hold: got gs=%b life=%0d score=%0d want gs=01 life=3 score=0",
               bus.game_state, bus.life, bus.score);
    end
  endtask

  task automatic test_hit();
    int drops = 0;
    logic [1:0] prev;
    prev = bus.life;
    for (int i = 0; i < 60 && m_state == 1; i++) begin
      box = m_fire & (~m_fire + 9'd1);
      cyc();
      tests++;
      if (dut_vec() !== mod_vec()) begin
        fails++;
        $display("FAIL hit_c%0d: got %h want %h", i, dut_vec(), mod_vec());
      end
      if (bus.life !== prev) begin
        drops++;
        tests++;
        if (bus.life !== prev - 2'd1) begin
          fails++;
          $display("FAIL hit_step: got life=%0d want %0d", bus.life, prev - 2'd1);
        end
        prev = bus.life;
      end
    end
    box = 9'h000;
    tests++;
    if (drops != 3 || bus.game_state !== 2'b10 || bus.life !== 2'd0 || bus.win !== 1'b0 ||
        {bus.fire_state, bus.gold_state, bus.next_fire_pattern} !== 27'd0) begin
      fails++;
      $display("FAIL hit_end: got drops=%0d gs=%b life=%0d win=%b want 3 10 0 0, grids 0",
               drops, bus.game_state, bus.life, bus.win);
    end
  endtask

  task automatic test_restart();
    start = 1'b1;
    cyc();
    start = 1'b0;
    tests++;
    if (bus.game_state !== 2'b00 || bus.life !== 2'd0 ||
        {bus.fire_state, bus.gold_state, bus.next_fire_pattern} !== 27'd0) begin
      fails++;
      $display("FAIL restart_init: got gs=%b life=%0d want gs=00 life=0 held, grids 0",
               bus.game_state, bus.life);
    end
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    tests++;
    if (bus.game_state !== 2'b01 || bus.life !== 2'd3 || bus.score !== 4'd0 ||
        dut_vec() !== mod_vec()) begin
      fails++;
      $display("FAIL restart_play: got %h want %h", dut_vec(), mod_vec());
    end
  endtask

  task automatic test_gold();
    int ups = 0;
    logic [3:0] prev;
    prev = bus.score;
    for (int i = 0; i < 80 && m_state == 1; i++) begin
      box = m_gold;
      cyc();
      tests++;
      if (dut_vec() !== mod_vec()) begin
        fails++;
        $display("FAIL gold_c%0d: got %h want %h", i, dut_vec(), mod_vec());
      end
      if (bus.score !== prev) begin
        ups++;
        tests++;
        if (bus.score !== prev + 4'd1) begin
          fails++;
          $display("FAIL gold_step: got score=%0d want %0d", bus.score, prev + 4'd1);
        end
        prev = bus.score;
      end
    end
    box = 9'h000;
    tests++;
    if (ups != 5 || bus.score !== 4'd5 || bus.game_state !== 2'b10 || bus.win !== 1'b1 ||
        bus.life !== 2'd3) begin
      fails++;
      $display("FAIL gold_end: got ups=%0d score=%0d gs=%b win=%b want 5 5 10 1",
               ups, bus.score, bus.game_state, bus.win);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 20 && m_warn; i++) cyc();
    tests++;
    if (m_warn || bus.fire_state === 9'h000) begin
      fails++;
      $display("FAIL reach_fire: got fire=%h want nonzero within budget", bus.fire_state);
    end
    box = m_fire;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    box = 9'h000;
    tests++;
    if (dut_vec() !== {2'b00, 27'd0, 2'd3, 4'd0, 1'b0}) begin
      fails++;
      $display("FAIL reset_mid: got %h want %h", dut_vec(), {2'b00, 27'd0, 2'd3, 4'd0, 1'b0});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      box   = 9'($urandom);
      start = ($urandom_range(0, 15) == 0);
      cyc();
      tests++;
      if (dut_vec() !== mod_vec()) begin
        fails++;
        $display("FAIL rand_c%0d: got %h want %h", i, dut_vec(), mod_vec());
      end
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start();
    test_idle();
    test_hit();
    test_restart();
    test_gold();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
